// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle between a producer/consumer pair and fifo_sync_param.
// The master side drives requests and write data; the slave side is the FIFO.
interface fifo_sync_param_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: register-array storage with a registered read port,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module fifo_sync_param #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int AF_TH  = 6,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  fifo_sync_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_TH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  generate
    if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af_th
      $error("fifo_sync_param: AF_TH must lie in 1..DEPTH");
    end
    if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae_th
      $error("fifo_sync_param: AE_TH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              valid_out_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic full_w;
  logic empty_w;
  logic rd_ok;
  logic wr_ok;

  assign full_w  = (count_reg == DEPTH_C);
  assign empty_w = (count_reg == '0);

  // A write into a full FIFO still goes through when a read frees a slot on the same edge.
  assign rd_ok = bus.rd_en & ~empty_w;
  assign wr_ok = bus.wr_en & (~full_w | rd_ok);

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + ONE_C;
      2'b01:   count_next = count_reg - ONE_C;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr_reg] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        data_out_reg  <= mem[rd_ptr_reg];
        valid_out_reg <= 1'b1;
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
      end else begin
        data_out_reg  <= '0;
        valid_out_reg <= 1'b0;
      end
      if (bus.wr_en & full_w & ~rd_ok) begin
        overflow_reg <= 1'b1;
      end
      if (bus.rd_en & empty_w) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.valid_out    = valid_out_reg;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed scenarios on the default 8x12 build and a
// randomized stream on a 16x16 build, both checked against a queue-based model.
module tb_fifo_sync_param;
  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_pass;

  fifo_sync_param_if #(.DATA_W(12), .ADDR_W(3)) ifa ();
  fifo_sync_param_if #(.DATA_W(16), .ADDR_W(4)) ifb ();

  fifo_sync_param #(.DATA_W(12), .ADDR_W(3), .AF_TH(6), .AE_TH(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  fifo_sync_param #(.DATA_W(16), .ADDR_W(4), .AF_TH(14), .AE_TH(3)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the last pop and sticky errors.
  logic [11:0] qa[$];
  logic [11:0] exp_dout_a;
  bit          exp_valid_a, ovf_a, udf_a;

  logic [15:0] qb[$];
  logic [15:0] exp_dout_b;
  bit          exp_valid_b, ovf_b, udf_b;

  function automatic logic [22:0] exp_a();
    int n = qa.size();
    return {4'(n), n == 8, n == 0, n >= 6, n <= 2, exp_valid_a, exp_dout_a, ovf_a, udf_a};
  endfunction

  function automatic logic [22:0] obs_a();
    return {ifa.count, ifa.full, ifa.empty, ifa.almost_full, ifa.almost_empty,
            ifa.valid_out, ifa.data_out, ifa.overflow, ifa.underflow};
  endfunction

  function automatic logic [27:0] exp_b();
    int n = qb.size();
    return {5'(n), n == 16, n == 0, n >= 14, n <= 3, exp_valid_b, exp_dout_b, ovf_b, udf_b};
  endfunction

  function automatic logic [27:0] obs_b();
    return {ifb.count, ifb.full, ifb.empty, ifb.almost_full, ifb.almost_empty,
            ifb.valid_out, ifb.data_out, ifb.overflow, ifb.underflow};
  endfunction

  task automatic step_a(input bit wr, input logic [11:0] d, input bit rd);
    bit rd_ok, wr_ok;
    ifa.wr_en = wr; ifa.data_in = d; ifa.rd_en = rd;
    rd_ok = rd && qa.size() > 0;
    wr_ok = wr && (qa.size() < 8 || rd_ok);
    if (wr && qa.size() == 8 && !rd_ok) ovf_a = 1;
    if (rd && qa.size() == 0) udf_a = 1;
    if (rd_ok) begin exp_dout_a = qa.pop_front(); exp_valid_a = 1; end
    else begin exp_dout_a = '0; exp_valid_a = 0; end
    if (wr_ok) qa.push_back(d);
    @(posedge clk); #1;
    ifa.wr_en = 0; ifa.rd_en = 0;
    $display("A wr=%0b din=%h rd=%0b -> count=%0d dout=%h valid=%0b ovf=%0b udf=%0b",
             wr, d, rd, ifa.count, ifa.data_out, ifa.valid_out, ifa.overflow, ifa.underflow);
  endtask

  task automatic reset_a(input bit wr);
    rst_a = 1; ifa.wr_en = wr; ifa.data_in = 12'h3FF; ifa.rd_en = 0;
    @(posedge clk); #1;
    rst_a = 0; ifa.wr_en = 0;
    qa.delete(); exp_dout_a = '0; exp_valid_a = 0; ovf_a = 0; udf_a = 0;
    $display("A reset wr=%0b -> count=%0d", wr, ifa.count);
  endtask

  task automatic step_b(input bit wr, input logic [15:0] d, input bit rd);
    bit rd_ok, wr_ok;
    ifb.wr_en = wr; ifb.data_in = d; ifb.rd_en = rd;
    rd_ok = rd && qb.size() > 0;
    wr_ok = wr && (qb.size() < 16 || rd_ok);
    if (wr && qb.size() == 16 && !rd_ok) ovf_b = 1;
    if (rd && qb.size() == 0) udf_b = 1;
    if (rd_ok) begin exp_dout_b = qb.pop_front(); exp_valid_b = 1; end
    else begin exp_dout_b = '0; exp_valid_b = 0; end
    if (wr_ok) qb.push_back(d);
    @(posedge clk); #1;
    ifb.wr_en = 0; ifb.rd_en = 0;
    $display("B wr=%0b din=%h rd=%0b -> count=%0d dout=%h valid=%0b",
             wr, d, rd, ifb.count, ifb.data_out, ifb.valid_out);
  endtask

  task automatic test_reset();
    reset_a(0);
    n_checks++;
    if (obs_a() !== exp_a()) $display("FAIL reset_status: got %h expected %h", obs_a(), exp_a());
    else n_pass++;
    n_checks++;
    if ({ifa.empty, ifa.almost_empty, ifa.full, ifa.almost_full} !== 4'b1100)
      $display("FAIL reset_flags: got %b expected 1100",
               {ifa.empty, ifa.almost_empty, ifa.full, ifa.almost_full});
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step_a(1, 12'(i), 0);
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL fill_status[%0d]: got %h expected %h", i, obs_a(), exp_a());
      else n_pass++;
      n_checks++;
      if ({ifa.count, ifa.almost_full, ifa.full} !== {4'(i), i >= 6, i == 8})
        $display("FAIL fill_flags[%0d]: got %h expected %h", i,
                 {ifa.count, ifa.almost_full, ifa.full}, {4'(i), i >= 6, i == 8});
      else n_pass++;
    end
  endtask

  task automatic test_overflow_drain();
    step_a(1, 12'hABC, 0);
    n_checks++;
    if ({ifa.overflow, ifa.count} !== {1'b1, 4'd8})
      $display("FAIL overflow_set: got ovf=%0b count=%0d expected ovf=1 count=8", ifa.overflow, ifa.count);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      step_a(0, '0, 1);
      n_checks++;
      if ({ifa.valid_out, ifa.data_out} !== {1'b1, 12'(i)})
        $display("FAIL drain_data[%0d]: got valid=%0b dout=%h expected valid=1 dout=%h",
                 i, ifa.valid_out, ifa.data_out, 12'(i));
      else n_pass++;
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL drain_status[%0d]: got %h expected %h", i, obs_a(), exp_a());
      else n_pass++;
    end
    n_checks++;
    if ({ifa.empty, ifa.overflow} !== 2'b11)
      $display("FAIL drain_end: got empty=%0b ovf=%0b expected 1 1", ifa.empty, ifa.overflow);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] tail [8];
    tail = '{12'h005, 12'h006, 12'h007, 12'h008, 12'h100, 12'h101, 12'h102, 12'h103};
    reset_a(0);
    for (int i = 1; i <= 8; i++) step_a(1, 12'(i), 0);
    for (int i = 0; i < 4; i++) begin
      step_a(1, 12'h100 + 12'(i), 1);
      n_checks++;
      if ({ifa.data_out, ifa.count, ifa.full, ifa.overflow} !== {12'(i + 1), 4'd8, 1'b1, 1'b0})
        $display("FAIL b2b_full[%0d]: got dout=%h count=%0d full=%0b ovf=%0b expected %h 8 1 0",
                 i, ifa.data_out, ifa.count, ifa.full, ifa.overflow, 12'(i + 1));
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      step_a(0, '0, 1);
      n_checks++;
      if ({ifa.valid_out, ifa.data_out} !== {1'b1, tail[i]})
        $display("FAIL wrap_data[%0d]: got valid=%0b dout=%h expected valid=1 dout=%h",
                 i, ifa.valid_out, ifa.data_out, tail[i]);
      else n_pass++;
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL wrap_status[%0d]: got %h expected %h", i, obs_a(), exp_a());
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    step_a(1, 12'h055, 1);
    n_checks++;
    if ({ifa.underflow, ifa.valid_out, ifa.data_out, ifa.count} !== {1'b1, 1'b0, 12'h000, 4'd1})
      $display("FAIL empty_rw: got udf=%0b valid=%0b dout=%h count=%0d expected 1 0 000 1",
               ifa.underflow, ifa.valid_out, ifa.data_out, ifa.count);
    else n_pass++;
    step_a(0, '0, 1);
    n_checks++;
    if ({ifa.valid_out, ifa.data_out} !== {1'b1, 12'h055})
      $display("FAIL empty_rw_next: got valid=%0b dout=%h expected valid=1 dout=055",
               ifa.valid_out, ifa.data_out);
    else n_pass++;
    n_checks++;
    if (obs_a() !== exp_a()) $display("FAIL empty_rw_status: got %h expected %h", obs_a(), exp_a());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    reset_a(0);
    for (int i = 0; i < 5; i++) step_a(1, 12'h200 + 12'(i), 0);
    reset_a(1);
    n_checks++;
    if ({ifa.count, ifa.empty, ifa.overflow, ifa.underflow, ifa.valid_out} !== {4'd0, 1'b1, 3'b000})
      $display("FAIL mid_reset: got count=%0d empty=%0b ovf=%0b udf=%0b valid=%0b expected 0 1 0 0 0",
               ifa.count, ifa.empty, ifa.overflow, ifa.underflow, ifa.valid_out);
    else n_pass++;
    step_a(0, '0, 1);
    n_checks++;
    if ({ifa.underflow, ifa.valid_out, ifa.count} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL mid_reset_read: got udf=%0b valid=%0b count=%0d expected 1 0 0",
               ifa.underflow, ifa.valid_out, ifa.count);
    else n_pass++;
  endtask

  task automatic test_random_wide();
    int written = 0;
    int cycles  = 0;
    bit wr, rd;
    rst_b = 1;
    @(posedge clk); #1;
    rst_b = 0;
    qb.delete(); exp_dout_b = '0; exp_valid_b = 0; ovf_b = 0; udf_b = 0;
    while ((written < 40 || qb.size() > 0) && cycles < 600) begin
      wr = (written < 40) && ($urandom_range(0, 99) < 60);
      rd = $urandom_range(0, 99) < ((written < 40) ? 40 : 75);
      if (wr && (qb.size() < 16 || (rd && qb.size() > 0))) written++;
      step_b(wr, 16'($urandom), rd);
      cycles++;
      n_checks++;
      if (obs_b() !== exp_b()) $display("FAIL rand_status[%0d]: got %h expected %h", cycles, obs_b(), exp_b());
      else n_pass++;
      n_checks++;
      if (ifb.count > 5'd16) $display("FAIL rand_bound[%0d]: got count=%0d expected <=16", cycles, ifb.count);
      else n_pass++;
    end
    n_checks++;
    if (cycles >= 600) $display("FAIL rand_timeout: got %0d cycles expected under 600", cycles);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_a = 1; rst_b = 1;
    ifa.wr_en = 0; ifa.rd_en = 0; ifa.data_in = '0;
    ifb.wr_en = 0; ifb.rd_en = 0; ifb.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 0;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_back_to_back();
    test_underflow();
    test_mid_reset();
    test_random_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
